uart_stepper_ctrl: RTL and testbench

- UART receiver (8N1, LSB first) and single 4-phase stepper driver in one block.
- Each received byte is a motor command. It is exposed on rx_byte with a one-cycle rbyte_ready strobe.
- The command immediately updates the coil outputs f0..f3.
- Sits between a host serial line (e.g. Raspberry Pi TX) and the stepper power stage.

---
 rtl/uart_stepper_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_stepper_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_stepper_ctrl.sv
// UART 8N1 command receiver driving a single 4-phase stepper (f0..f3).
// Optional `define COIL_TIMEOUT_EN de-energizes the coils after TIMEOUT_CLKS idle clocks.
module uart_stepper_ctrl #(
    parameter int unsigned BAUD_DIV     = 868,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned TIMEOUT_CLKS = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rbyte_ready,
    output logic       f0,
    output logic       f1,
    output logic       f2,
    output logic       f3
);

    localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    // Parameter sanity, evaluated at elaboration only
    if (BAUD_DIV < 4) begin : g_bad_baud_div
        $error("BAUD_DIV must be at least 4");
    end
    if (SYNC_STAGES < 1) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be at least 1");
    end
    if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
        $error("TIMEOUT_CLKS must be nonzero");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_d;
    logic                   w_rx;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bit;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             w_byte_ok;
    logic [7:0]       r_rx_byte;
    logic             r_rbyte_ready;

    logic [2:0] r_idx;
    logic [2:0] w_idx_nxt;
    logic [2:0] w_delta;
    logic       r_released;
    logic       w_rel_nxt;
    logic [3:0] r_coils;

    // rx synchronizer, preset to idle-high so reset never looks like a start edge
    assign w_rx = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= SYNC_STAGES'({r_sync, rx});
            r_rx_d <= w_rx;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit         <= 3'd0;
            r_shift       <= 8'h00;
            r_rx_byte     <= 8'h00;
            r_rbyte_ready <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_bit         <= w_bit_nxt;
            r_shift       <= w_shift_nxt;
            r_rbyte_ready <= w_byte_ok;
            if (w_byte_ok) begin
                r_rx_byte <= r_shift;
            end
        end
    end

    // Receiver next-state logic; r_cnt hitting zero marks the mid-bit sample point
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_byte_ok   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rx_d && !w_rx) begin
                    w_cnt_nxt   = HALF_BIT;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == '0) begin
                    if (w_rx) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = FULL_BIT;
                        w_bit_nxt   = 3'd0;
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == '0) begin
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    w_cnt_nxt   = FULL_BIT;
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == '0) begin
                    if (w_rx) begin
                        w_byte_ok   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (w_rx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef COIL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [TO_W-1:0] r_idle_cnt;
    logic            w_to_hit;

    // Saturating idle counter; fires once when it reaches TIMEOUT_CLKS
    assign w_to_hit = (r_idle_cnt == TO_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (r_rbyte_ready) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TO_W'(TIMEOUT_CLKS)) begin
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
        end
    end
`endif

    // Command decode: bit0 STEP, bit1 DIR, bit2 RELEASE, bit3 HALF
    always_comb begin
        w_idx_nxt = r_idx;
        w_rel_nxt = r_released;
        w_delta   = r_rx_byte[3] ? 3'd1 : 3'd2;
        if (r_rbyte_ready) begin
            w_rel_nxt = r_rx_byte[2];
            if (r_rx_byte[0]) begin
                w_idx_nxt = r_rx_byte[1] ? (r_idx - w_delta) : (r_idx + w_delta);
            end
        end
`ifdef COIL_TIMEOUT_EN
        else if (w_to_hit) begin
            w_rel_nxt = 1'b1;
        end
`endif
    end

    // Coil pattern {f0,f1,f2,f3}; odd indices are two-coil, even are wave drive
    function automatic logic [3:0] phase_coils(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= 3'd1;
            r_released <= 1'b1;
            r_coils    <= 4'b0000;
        end else begin
            r_idx      <= w_idx_nxt;
            r_released <= w_rel_nxt;
            r_coils    <= w_rel_nxt ? 4'b0000 : phase_coils(w_idx_nxt);
        end
    end

    assign rx_byte     = r_rx_byte;
    assign rbyte_ready = r_rbyte_ready;
    assign f0          = r_coils[3];
    assign f1          = r_coils[2];
    assign f2          = r_coils[1];
    assign f3          = r_coils[0];

endmodule

// File: tb/tb_uart_stepper_ctrl.sv
// Directed bench for uart_stepper_ctrl: serial command frames in, strobe/byte/coil pattern checked.
module tb_uart_stepper_ctrl;

    localparam int unsigned DIV = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_byte;
    logic       rbyte_ready;
    logic       f0, f1, f2, f3;
    logic [3:0] coils;

    int n_checks   = 0;
    int n_fail     = 0;
    int strobe_cnt = 0;

    uart_stepper_ctrl #(
        .BAUD_DIV     (DIV),
        .SYNC_STAGES  (2),
        .TIMEOUT_CLKS (5000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .rx_byte     (rx_byte),
        .rbyte_ready (rbyte_ready),
        .f0          (f0),
        .f1          (f1),
        .f2          (f2),
        .f3          (f3)
    );

    assign coils = {f0, f1, f2, f3};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rbyte_ready === 1'b1) strobe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int n, input logic stop_v);
        logic [7:0] d;
        d = b;
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(d[i], n);
        drive_bit(stop_v, n);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_strobe(input int max_clks, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_clks; i++) begin
            @(negedge clk);
            if (rbyte_ready === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        bit found;

        // Reset and idle line
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_coils", 32'(coils), 32'h0);
        check("rst_ready", 32'(rbyte_ready), 32'h0);
        check("rst_byte", 32'(rx_byte), 32'h0);
        rst_n = 1'b1;
        idle(10 * DIV);
        check("idle_coils", 32'(coils), 32'h0);
        check("idle_strobes", 32'(strobe_cnt), 32'h0);
        check("idle_byte", 32'(rx_byte), 32'h0);

        // 0x01 sent slightly slow: one step forward full, 1 -> 3
        fork
            send_byte(8'h01, DIV + 1, 1'b1);
            begin
                wait_strobe(12 * (DIV + 1), found);
                check("slow_seen", 32'(found), 32'h1);
                check("slow_byte", 32'(rx_byte), 32'h01);
                check("slow_coils_latency", 32'(coils), 32'h0);
                @(negedge clk);
                check("slow_coils", 32'(coils), 32'b0110);
                check("slow_strobe_width", 32'(rbyte_ready), 32'h0);
            end
        join
        idle(2 * DIV);
        check("slow_strobes", 32'(strobe_cnt), 32'h1);

        // 50 back-to-back frames: 10 full steps from index 1 -> 5
        do_reset();
        base = strobe_cnt;
        for (int r = 0; r < 10; r++) begin
            send_byte(8'h01, DIV, 1'b1);
            for (int z = 0; z < 4; z++) send_byte(8'h00, DIV, 1'b1);
        end
        idle(2 * DIV);
        check("b2b_strobes", 32'(strobe_cnt - base), 32'd50);
        check("b2b_coils", 32'(coils), 32'b0011);
        check("b2b_byte", 32'(rx_byte), 32'h00);

        // Half/full, forward/reverse, release
        do_reset();
        send_byte(8'h09, DIV, 1'b1); idle(DIV);
        check("half_fwd_1to2", 32'(coils), 32'b0100);
        send_byte(8'h03, DIV, 1'b1); idle(DIV);
        check("full_rev_2to0", 32'(coils), 32'b1000);
        send_byte(8'h07, DIV, 1'b1); idle(DIV);
        check("release_step_0to6", 32'(coils), 32'b0000);
        send_byte(8'h00, DIV, 1'b1); idle(DIV);
        check("energize_hold_6", 32'(coils), 32'b0001);
        send_byte(8'h0B, DIV, 1'b1); idle(DIV);
        check("half_rev_6to5", 32'(coils), 32'b0011);
        check("half_rev_byte", 32'(rx_byte), 32'h0B);

        // Release without step, then a framing error, then recovery
        send_byte(8'h04, DIV, 1'b1); idle(DIV);
        check("release_only", 32'(coils), 32'b0000);
        base = strobe_cnt;
        send_byte(8'h55, DIV, 1'b0);
        idle(3 * DIV);
        check("frame_err_strobes", 32'(strobe_cnt - base), 32'h0);
        check("frame_err_coils", 32'(coils), 32'b0000);
        check("frame_err_byte", 32'(rx_byte), 32'h04);
        send_byte(8'h0A, DIV, 1'b1); idle(DIV);
        check("after_err_strobes", 32'(strobe_cnt - base), 32'h1);
        check("after_err_byte", 32'(rx_byte), 32'h0A);
        check("after_err_coils", 32'(coils), 32'b0011);

        // Half-bit low glitch must not start a frame
        base = strobe_cnt;
        drive_bit(1'b0, DIV / 2);
        idle(4 * DIV);
        check("glitch_strobes", 32'(strobe_cnt - base), 32'h0);
        check("glitch_byte", 32'(rx_byte), 32'h0A);
        send_byte(8'h01, DIV, 1'b1); idle(DIV);
        check("post_glitch_5to7", 32'(coils), 32'b1001);
        check("post_glitch_strobes", 32'(strobe_cnt - base), 32'h1);

        // Reset asserted mid DATA bit
        drive_bit(1'b0, DIV);
        drive_bit(1'b1, DIV + DIV / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_byte", 32'(rx_byte), 32'h0);
        check("midrst_ready", 32'(rbyte_ready), 32'h0);
        check("midrst_coils", 32'(coils), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        base = strobe_cnt;
        idle(12 * DIV);
        check("midrst_no_strobe", 32'(strobe_cnt - base), 32'h0);
        send_byte(8'h01, DIV, 1'b1); idle(DIV);
        check("midrst_index_reset", 32'(coils), 32'b0110);
        check("midrst_rx_ok", 32'(rx_byte), 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
